// File: rtl/rc4_key_search_sequencer.sv
// -----------------------------------------------------------------------------
// rc4_key_search_sequencer
//
// Top-level scheduler for the RC4 key-search loop. For every candidate key it
// steps the shared S-RAM controller through init -> shuffle -> decrypt via a
// one-hot mode select. While the decrypt phase runs it watches result-RAM
// writes; any byte that is not a space or a lowercase letter marks the key as
// bad. After decrypt the key is either reported or incremented and retried.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset
//   start         launch a search (honoured only in IDLE or a DONE state)
//   finish_bus    done flags: bit0 initializer, bit1 shuffler, bit2 decryptor
//   a_wren_snoop  result-RAM write enable seen by the decryptor
//   a_data_snoop  result-RAM write data
//   mode          one-hot phase select: 001 init, 010 shuffle, 100 decrypt
//   key           current candidate key, key[KEY_LENGTH-1] is the MSB byte
//   busy          search in progress
//   found         key holds a plaintext-producing key
//   exhausted     KEY_END tried without success
//   timeout       a phase exceeded TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module rc4_key_search_sequencer #(
    parameter int RAM_WIDTH      = 8,
    parameter int KEY_LENGTH     = 3,
    parameter int NUM_DEVICES    = 3,
    parameter logic [KEY_LENGTH*RAM_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_LENGTH*RAM_WIDTH-1:0] KEY_END   = 24'h3FFFFF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [NUM_DEVICES-1:0]               finish_bus,
    input  logic                                 a_wren_snoop,
    input  logic [RAM_WIDTH-1:0]                 a_data_snoop,
    output logic [2:0]                           mode,
    output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
    output logic                                 busy,
    output logic                                 found,
    output logic                                 exhausted,
    output logic                                 timeout
);

    localparam int KW = KEY_LENGTH * RAM_WIDTH;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, INIT, GAP1, SHUF, GAP2, DEC, GAP3, CHECK,
        DONE_FOUND, DONE_FAIL, DONE_TO
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   key_q, key_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      mode_d;
    logic            bad_q, bad_d;
    logic            busy_d, found_d, exhausted_d, timeout_d;
    logic            snoop_bad;

    // Plaintext is accepted only as spaces and lowercase ASCII letters.
    assign snoop_bad = a_wren_snoop &&
                       !((a_data_snoop == RAM_WIDTH'(8'h20)) ||
                         ((a_data_snoop >= RAM_WIDTH'(8'h61)) &&
                          (a_data_snoop <= RAM_WIDTH'(8'h7A))));

    assign key = key_q;

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        bad_d       = bad_q;
        busy_d      = busy;
        found_d     = found;
        exhausted_d = exhausted;
        timeout_d   = timeout;
        cnt_d       = '0;   // phase counter is zero outside the active phases

        case (state_q)
            IDLE, DONE_FOUND, DONE_FAIL, DONE_TO: begin
                if (start) begin
                    key_d       = KEY_START;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    timeout_d   = 1'b0;
                    busy_d      = 1'b1;
                    bad_d       = 1'b0;
                    state_d     = INIT;
                end
            end
            // In each phase a finish beats a simultaneous timeout threshold.
            INIT: begin
                if (finish_bus[0])          state_d = GAP1;
                else if (cnt_q == CNT_LAST) state_d = DONE_TO;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            SHUF: begin
                if (finish_bus[1])          state_d = GAP2;
                else if (cnt_q == CNT_LAST) state_d = DONE_TO;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            DEC: begin
                if (snoop_bad) bad_d = 1'b1;
                if (finish_bus[2])          state_d = GAP3;
                else if (cnt_q == CNT_LAST) state_d = DONE_TO;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            // Gaps wait for every finish flag to drop so the next device
            // sees a clean rising mode bit.
            GAP1: if (finish_bus == '0) state_d = SHUF;
            GAP2: if (finish_bus == '0) state_d = DEC;
            GAP3: if (finish_bus == '0) state_d = CHECK;
            CHECK: begin
                if (!bad_q) begin
                    found_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE_FOUND;
                end else if (key_q == KEY_END) begin
                    exhausted_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE_FAIL;
                end else begin
                    key_d   = key_q + 1'b1;   // wraps modulo 2^KW
                    bad_d   = 1'b0;
                    state_d = INIT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == DONE_TO && state_q != DONE_TO) begin
            timeout_d = 1'b1;
            busy_d    = 1'b0;
        end

        // mode is registered from the next state, so it tracks state exactly.
        case (state_d)
            INIT:    mode_d = 3'b001;
            SHUF:    mode_d = 3'b010;
            DEC:     mode_d = 3'b100;
            default: mode_d = 3'b000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode      <= 3'b000;
            key_q     <= KEY_START;
            cnt_q     <= '0;
            bad_q     <= 1'b0;
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode      <= mode_d;
            key_q     <= key_d;
            cnt_q     <= cnt_d;
            bad_q     <= bad_d;
            busy      <= busy_d;
            found     <= found_d;
            exhausted <= exhausted_d;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rc4_key_search_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rc4_key_search_sequencer
//
// Directed and randomized bench for the key-search sequencer. The bench plays
// the three S-RAM devices (initializer, shuffler, decryptor), decides for
// every candidate key whether its decrypted bytes form legal plaintext, and
// from that predicts which key is found, or that the range is exhausted.
// -----------------------------------------------------------------------------
module tb_rc4_key_search_sequencer;

    localparam logic [23:0] KS = 24'h000000;
    localparam logic [23:0] KE = 24'h000003;
    localparam int          TO = 1024;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [2:0]      finish_bus = 3'b000;
    logic            a_wren_snoop = 1'b0;
    logic [7:0]      a_data_snoop = 8'h00;
    logic [2:0]      mode;
    logic [2:0][7:0] key;
    logic            busy, found, exhausted, timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Decryptor model: bytes written one per cycle from phase start, plus an
    // optional write on the finish cycle itself.
    logic [7:0] dec_bytes[$];
    logic       fin_wr   = 1'b0;
    logic [7:0] fin_byte = 8'h00;

    always #5 clk = ~clk;

    rc4_key_search_sequencer #(
        .RAM_WIDTH(8), .KEY_LENGTH(3), .NUM_DEVICES(3),
        .KEY_START(KS), .KEY_END(KE), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .finish_bus(finish_bus),
        .a_wren_snoop(a_wren_snoop), .a_data_snoop(a_data_snoop),
        .mode(mode), .key(key), .busy(busy), .found(found),
        .exhausted(exhausted), .timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit byte_ok(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic [7:0] legal_byte();
        int r;
        r = int'($urandom_range(0, 26));
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    task automatic wait_mode(input logic [2:0] exp, input string tag, output int n);
        n = 0;
        while (mode !== exp && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, mode, exp);
    endtask

    // Called on the negedge of the phase's first cycle; returns on the negedge
    // at which the device lowers its finish flag.
    task automatic run_phase(input int dev, input int len, input int hold, input bit poke);
        logic [2:0] exp;
        bit held;
        exp  = 3'b001 << dev;
        held = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (mode !== exp) held = 1'b0;
            finish_bus = 3'b000;
            start      = poke && (i == 2);
            if (dev == 2 && i < dec_bytes.size()) begin
                a_wren_snoop = 1'b1;
                a_data_snoop = dec_bytes[i];
            end else if (dev == 2) begin
                a_wren_snoop = 1'b0;
                a_data_snoop = 8'($urandom_range(0, 31));
            end else begin
                a_wren_snoop = 1'b1;          // illegal byte outside decrypt
                a_data_snoop = 8'h00;
            end
            @(negedge clk);
        end
        if (mode !== exp) held = 1'b0;
        check($sformatf("mode held in phase %0d", dev), 32'(held), 32'd1);
        start      = 1'b0;
        finish_bus = exp;
        if (dev == 2) begin
            a_wren_snoop = fin_wr;
            a_data_snoop = fin_byte;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            a_wren_snoop = 1'b1;
            a_data_snoop = 8'h00;
            check($sformatf("gap while finish high %0d", h), mode, 3'b000);
        end
        @(negedge clk);
        check("gap after finish", mode, 3'b000);
        finish_bus   = 3'b000;
        a_wren_snoop = 1'b0;
    endtask

    // Called in the first INIT cycle; returns on the negedge after CHECK.
    task automatic run_key(input int li, input int ls, input int ld, input int hold0, input bit poke);
        int n;
        run_phase(0, li, hold0, 1'b0);
        wait_mode(3'b010, "enter shuffle", n);
        check("gap1 dwell", n, 1);
        run_phase(1, ls, 0, poke);
        wait_mode(3'b100, "enter decrypt", n);
        check("gap2 dwell", n, 1);
        run_phase(2, ld, 0, 1'b0);
        @(negedge clk);
        check("mode in check", mode, 3'b000);
        @(negedge clk);
    endtask

    task automatic start_search();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start to init latency", mode, 3'b001);
        check("busy after start", busy, 1'b1);
        check("key reloaded", key, KS);
        check("flags cleared", {found, exhausted, timeout}, 3'b000);
    endtask

    task automatic build_bytes(input int kind, input logic [23:0] k, input int ld);
        int cnt;
        dec_bytes.delete();
        fin_wr   = 1'b0;
        fin_byte = 8'h00;
        cnt = (kind == 0) ? ld : int'($urandom_range(3, ld));
        for (int i = 0; i < cnt; i++) begin
            case (kind)
                0:       dec_bytes.push_back(8'h61);
                1:       dec_bytes.push_back((i == 2 && k < 24'd2) ? 8'h41 : legal_byte());
                2:       dec_bytes.push_back(legal_byte());
                default: dec_bytes.push_back(($urandom_range(0, 3) == 0) ?
                                             8'($urandom_range(0, 255)) : legal_byte());
            endcase
        end
        if (kind == 2) begin
            if (k == KE) begin
                fin_wr   = 1'b1;              // bad byte on the finish cycle
                fin_byte = 8'h7B;
            end else begin
                dec_bytes[$urandom_range(0, cnt - 1)] = 8'h7B;
            end
        end
        if (kind == 3 && $urandom_range(0, 3) == 0) begin
            fin_wr   = 1'b1;
            fin_byte = 8'($urandom_range(0, 255));
        end
    endtask

    // Runs one whole search from the first INIT cycle, predicting the outcome
    // of every key from the bytes the decryptor model emits.
    task automatic search(input int kind, input int li, input int ls, input int ld, input int hold0);
        logic [23:0] k;
        bit good, done;
        int a, b, c;
        k    = KS;
        done = 1'b0;
        for (int guard = 0; guard < 8 && !done; guard++) begin
            a = (li != 0) ? li : int'($urandom_range(4, 40));
            b = (ls != 0) ? ls : int'($urandom_range(4, 40));
            c = (ld != 0) ? ld : int'($urandom_range(4, 40));
            build_bytes(kind, k, c);
            good = !(fin_wr && !byte_ok(fin_byte));
            foreach (dec_bytes[i]) if (!byte_ok(dec_bytes[i])) good = 1'b0;
            check("key under test", key, k);
            run_key(a, b, c, (guard == 0) ? hold0 : 0, kind == 1);
            if (good) begin
                check("found", found, 1'b1);
                check("busy after found", busy, 1'b0);
                check("found key", key, k);
                check("no exhaust on found", exhausted, 1'b0);
                check("mode idle when found", mode, 3'b000);
                done = 1'b1;
            end else if (k == KE) begin
                check("exhausted", exhausted, 1'b1);
                check("not found on exhaust", found, 1'b0);
                check("busy after exhaust", busy, 1'b0);
                check("key at end", key, KE);
                done = 1'b1;
            end else begin
                check("retry back to init", mode, 3'b001);
                check("busy during retry", busy, 1'b1);
                k = k + 24'd1;
            end
        end
        repeat (3) @(negedge clk);
        check("done state holds", {busy, mode}, 4'b0000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("reset mode", mode, 3'b000);
        check("reset key", key, KS);
        check("reset flags", {busy, found, exhausted, timeout}, 4'b0000);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle without start", {busy, mode}, 4'b0000);

        // Clean first key with long device latencies
        start_search();
        search(0, 256, 768, 64, 0);

        // Keys 0 and 1 bad in the third byte, key 2 clean; start poked mid-shuffle
        start_search();
        search(1, 0, 0, 0, 0);

        // Every key bad, the last one only on the finish cycle
        start_search();
        search(2, 0, 0, 0, 0);

        // Random plaintext, initializer finish held 5 extra cycles
        for (int r = 0; r < 3; r++) begin
            start_search();
            search(3, 0, 0, 0, (r == 0) ? 5 : 0);
        end

        // Finish exactly at the threshold wins, then the shuffler hangs
        start_search();
        run_phase(0, TO - 1, 0, 1'b0);
        wait_mode(3'b010, "shuffle after threshold finish", n);
        check("no timeout on threshold finish", timeout, 1'b0);
        n = 0;
        while (timeout !== 1'b1 && n < TO + 20) begin
            if (n == TO - 1) check("shuffle last cycle", mode, 3'b010);
            @(negedge clk);
            n++;
        end
        check("timeout latency", n, TO);
        check("timeout outputs", {busy, found, exhausted, mode}, 6'b000000);
        repeat (3) @(negedge clk);
        check("timeout holds", {timeout, mode}, 4'b1000);

        // Reset in the middle of decrypting the second key
        start_search();
        dec_bytes = '{8'h61, 8'h00, 8'h61};
        fin_wr    = 1'b0;
        run_key(6, 6, 6, 0, 1'b0);
        check("retry after bad key", mode, 3'b001);
        check("key incremented", key, KS + 24'd1);
        run_phase(0, 6, 0, 1'b0);
        wait_mode(3'b010, "enter shuffle key1", n);
        run_phase(1, 6, 0, 1'b0);
        wait_mode(3'b100, "enter decrypt key1", n);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid-run reset mode", mode, 3'b000);
        check("mid-run reset busy", busy, 1'b0);
        check("mid-run reset key", key, KS);
        reset = 1'b1;
        start_search();
        search(0, 8, 8, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
